// File: rtl/cpu_int_pkg.sv
// Shared interrupt encodings for the 6502C core: request kinds, front-end FSM states
// and default vector bases.
package cpu_int_pkg;

    typedef enum logic [1:0] {
        INT_BRK = 2'd0,
        INT_IRQ = 2'd1,
        INT_NMI = 2'd2,
        INT_RST = 2'd3
    } int_kind_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PEND     = 3'd1;
    localparam logic [2:0] ST_RST_PEND = 3'd2;
    localparam logic [2:0] ST_SERVICE  = 3'd3;
    localparam logic [2:0] ST_VECTOR   = 3'd4;

    localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
    localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

    // Only IRQ and BRK sequences may be redirected to the NMI vector.
    function automatic logic nmi_can_hijack(input int_kind_e kind);
        return (kind == INT_BRK) || (kind == INT_IRQ);
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for an asynchronous active-low pin, resetting to the idle-high
// level, with registered-history edge outputs.
module pin_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], pin};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level = chain_q[STAGES-1];
    assign fall  = prev_q & ~level;
    assign rise  = ~prev_q & level;

endmodule

// File: rtl/cpu_int_ctrl.sv
// Interrupt front-end for the 6502C core: synchronises NMI/IRQ/RES pins, arbitrates
// RST>NMI>IRQ>BRK at instruction boundaries and supplies the vector and B flag.
module cpu_int_ctrl
    import cpu_int_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_HOLD    = 2,
    parameter logic [15:0] VEC_NMI     = VEC_NMI_DEF,
    parameter logic [15:0] VEC_RST     = VEC_RST_DEF,
    parameter logic [15:0] VEC_IRQ     = VEC_IRQ_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        res_n,
    input  logic        sync,
    input  logic        rdy,
    input  logic        i_flag,
    input  logic        brk_op,
    input  logic        int_ack,
    input  logic        vec_fetch,
    output logic        int_req,
    output logic [1:0]  int_kind,
    output logic [15:0] vec_addr,
    output logic        b_push,
    output logic        no_write
);

    localparam int unsigned CNT_W = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RST_HOLD);

    logic nmi_lvl_unused, nmi_fall, nmi_rise_unused;
    logic irq_s, irq_fall_unused, irq_rise_unused;
    logic res_s, res_fall_unused, res_rise;

    pin_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (nmi_n),
        .level (nmi_lvl_unused),
        .fall  (nmi_fall),
        .rise  (nmi_rise_unused)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (irq_n),
        .level (irq_s),
        .fall  (irq_fall_unused),
        .rise  (irq_rise_unused)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_res_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (res_n),
        .level (res_s),
        .fall  (res_fall_unused),
        .rise  (res_rise)
    );

    logic [2:0]       state_q, state_d;
    int_kind_e        kind_q, kind_d, kind_eff;
    logic [15:0]      vec_addr_q, vec_addr_d;
    logic             b_push_q, b_push_d;
    logic             nmi_latch_q, nmi_latch_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             irq_lvl, res_arm, nmi_clr;

    function automatic logic [15:0] vec_of(input int_kind_e kind);
        case (kind)
            INT_NMI: return VEC_NMI;
            INT_RST: return VEC_RST;
            default: return VEC_IRQ;
        endcase
    endfunction

    assign irq_lvl = ~irq_s & ~i_flag;
    assign res_arm = res_rise && (rst_cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        vec_addr_d = vec_addr_q;
        b_push_d   = b_push_q;
        nmi_clr    = 1'b0;
        kind_eff   = kind_q;

        // A late NMI redirects an IRQ/BRK already past its acknowledge.
        if (state_q == ST_SERVICE && nmi_latch_q && nmi_can_hijack(kind_q)) begin
            kind_eff = INT_NMI;
        end

        if (res_arm) begin
            state_d  = ST_RST_PEND;
            kind_d   = INT_RST;
            b_push_d = 1'b0;
        end else if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        if (nmi_latch_q) begin
                            state_d  = ST_PEND;
                            kind_d   = INT_NMI;
                            b_push_d = 1'b0;
                        end else if (irq_lvl) begin
                            state_d  = ST_PEND;
                            kind_d   = INT_IRQ;
                            b_push_d = 1'b0;
                        end else if (brk_op) begin
                            state_d  = ST_PEND;
                            kind_d   = INT_BRK;
                            b_push_d = 1'b1;
                        end
                    end
                end
                ST_PEND, ST_RST_PEND: begin
                    if (int_ack) state_d = ST_SERVICE;
                end
                ST_SERVICE: begin
                    kind_d = kind_eff;
                    if (vec_fetch) begin
                        vec_addr_d = vec_of(kind_eff);
                        nmi_clr    = (kind_eff == INT_NMI);
                        state_d    = ST_VECTOR;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // An edge arriving in the clearing cycle survives for the next boundary.
        nmi_latch_d = (nmi_latch_q & ~nmi_clr) | nmi_fall;

        if (!res_s) begin
            rst_cnt_d = (rst_cnt_q == CNT_MAX) ? CNT_MAX : rst_cnt_q + 1'b1;
        end else begin
            rst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RST_PEND;
            kind_q      <= INT_RST;
            vec_addr_q  <= VEC_RST;
            b_push_q    <= 1'b0;
            nmi_latch_q <= 1'b0;
            rst_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            vec_addr_q  <= vec_addr_d;
            b_push_q    <= b_push_d;
            nmi_latch_q <= nmi_latch_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    assign int_req  = (state_q == ST_PEND) || (state_q == ST_RST_PEND);
    assign int_kind = kind_q;
    assign vec_addr = vec_addr_q;
    assign b_push   = b_push_q;
    assign no_write = (state_q != ST_IDLE) && (kind_q == INT_RST);

endmodule
